// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the ALU/SFU core: queues host commands, issues them one at a time,
// and holds each result behind a valid/ready handshake. `SEQ_TIMEOUT_EN` adds a WAIT watchdog.
module alu_cmd_sequencer #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [7:0]  core_ui,
   output logic [7:0]  core_uio,
   input  logic [7:0]  core_uo,
   input  logic [4:0]  core_flags,
   output logic [7:0]  res_data,
   output logic [3:0]  res_flags,
   output logic        res_valid,
   input  logic        res_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic       mode;
      logic [2:0] sel;
      logic [7:0] payload;
   } cmd_t;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_HOLD} state_t;

   if (DEPTH < 2 || (1 << AW) != DEPTH || TIMEOUT_CYCLES < 2) begin : g_bad_param
      $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
   end

   state_t         state, state_nxt;
   cmd_t           mem [DEPTH];
   cmd_t           cur;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           push, pop, result_seen, timed_out, capture;
   logic           unused_bits;

   assign unused_bits = ^{cmd_data[11:8], core_flags[4]};

   assign cmd_ready   = (count != FULL_CNT);
   assign push        = cmd_valid & cmd_ready;
   assign pop         = (state == S_IDLE) && (count != '0);
   assign result_seen = (state == S_WAIT) && core_flags[3];
   assign capture     = (state == S_SETTLE) || result_seen || timed_out;

`ifdef SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] wait_cnt;

   // Counter sits at zero outside WAIT, so it is zero on every WAIT entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  wait_cnt <= '0;
      else if (state != S_WAIT) wait_cnt <= '0;
      else                      wait_cnt <= wait_cnt + 1'b1;
   end

   assign timed_out = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{cmd_data[15], cmd_data[14:12], cmd_data[7:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cur    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            cur    <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (pop) state_nxt = S_ISSUE;
         S_ISSUE:  state_nxt = cur.mode ? S_SETTLE : S_WAIT;
         S_WAIT:   if (result_seen || timed_out) state_nxt = S_HOLD;
         S_SETTLE: state_nxt = S_HOLD;
         S_HOLD:   if (res_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Pins follow `cur` continuously; only the ALU start bit depends on state.
   always_comb begin
      core_ui  = '0;
      core_uio = '0;
      if (cur.mode) begin
         core_ui  = cur.payload;
         core_uio = {3'b000, 1'b1, 1'b0, cur.sel};
      end else begin
         core_ui  = {(state == S_ISSUE), cur.sel, cur.payload[3:0]};
         core_uio = {4'b0000, cur.payload[7:4]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data  <= '0;
         res_flags <= '0;
         res_valid <= 1'b0;
      end else if (capture) begin
         res_valid <= 1'b1;
         // A result sampled on the watchdog edge wins over the timeout.
         if (timed_out && !result_seen) begin
            res_data  <= '0;
            res_flags <= 4'b1000;
         end else begin
            res_data  <= core_uo;
            res_flags <= {1'b0, core_flags[2:0]};
         end
      end else if (state == S_HOLD && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed + randomized bench for alu_cmd_sequencer with a small behavioural ALU/SFU core model.
module tb_alu_cmd_sequencer;

   logic        clk, rst;
   logic [15:0] cmd_data;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  core_ui, core_uio, core_uo;
   logic [4:0]  core_flags;
   logic [7:0]  res_data;
   logic [3:0]  res_flags;
   logic        res_valid, res_ready;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [11:0] exp_q [$];
   logic        core_mute;

   alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .core_ui(core_ui), .core_uio(core_uio),
      .core_uo(core_uo), .core_flags(core_flags),
      .res_data(res_data), .res_flags(res_flags),
      .res_valid(res_valid), .res_ready(res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: ALU result_valid two cycles after start, SFU passes x through combinationally.
   logic       p1, p2;
   logic [7:0] alu_res;
   wire        sfu_mode  = core_uio[4];
   wire        alu_start = core_ui[7] & ~sfu_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p1 <= 1'b0; p2 <= 1'b0; alu_res <= '0;
      end else begin
         p1 <= alu_start;
         p2 <= p1 & ~core_mute;
         if (alu_start) alu_res <= {4'b0, core_ui[3:0]} + {4'b0, core_uio[3:0]};
      end
   end

   assign core_uo    = sfu_mode ? core_ui : alu_res;
   assign core_flags = {p1 | p2, p2, 1'b0, alu_res[4] & ~sfu_mode, core_uo == 8'h00};

   function automatic logic [11:0] model_res(input logic [15:0] d);
      logic [7:0] s;
      if (d[15]) return {d[7:0], 3'b000, d[7:0] == 8'h00};
      s = {4'b0, d[3:0]} + {4'b0, d[7:4]};
      return {s, 2'b00, s[4], s == 8'h00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic [15:0] d);
      bit ok = 0;
      cmd_data  = d;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (cmd_ready) ok = 1;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("push_accepted", 32'(ok), 32'd1);
      if (ok) exp_q.push_back(model_res(d));
   endtask

   task automatic take_result(input string tag, input int hold_cyc);
      logic [11:0] e;
      logic [7:0]  d0;
      int t = 0;
      while (!res_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_expected_pending"}, 32'(exp_q.size() > 0), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
      chk({tag, "_data"},  32'(res_data),  32'(e[11:4]));
      chk({tag, "_flags"}, 32'(res_flags), 32'(e[3:0]));
      d0 = res_data;
      repeat (hold_cyc) @(negedge clk);
      if (hold_cyc > 0) chk({tag, "_held_data"}, 32'(res_data), 32'(d0));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_dropped"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] fill [5];
      int cnt, first, n_acc, starts, vhits;
      logic [7:0] d0;

      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; res_ready = 1'b0; core_mute = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_core_ui",   32'(core_ui),   32'd0);
      chk("rst_core_uio",  32'(core_uio),  32'd0);
      chk("rst_res_data",  32'(res_data),  32'd0);
      chk("rst_res_flags", 32'(res_flags), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // ALU a=3 b=4: start visible for exactly one cycle, the cycle after the pop.
      push_cmd(16'h0043);
      cnt = 0; first = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (core_ui == 8'h83) begin
            cnt++;
            if (first == 0) first = k;
         end
      end
      chk("alu_start_count", 32'(cnt), 32'd1);
      chk("alu_start_cycle", 32'(first), 32'd1);
      take_result("alu_3p4", 0);

      // SFU x=0 func=2: result at E+3.
      push_cmd(16'hA000);
      @(negedge clk);
      chk("sfu_core_uio", 32'(core_uio), 32'h12);
      @(negedge clk);
      chk("sfu_valid_e2", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("sfu_valid_e3", 32'(res_valid), 32'd1);
      take_result("sfu_zero", 0);

      // FIFO fill while a result is held.
      push_cmd(16'h8055);
      cnt = 0;
      while (!res_valid && cnt < 50) begin @(negedge clk); cnt++; end
      fill = '{16'h0021, 16'h9F80, 16'h1255, 16'hC0FF, 16'h0077};
      n_acc = 0;
      for (int k = 0; k < 5; k++) begin
         cmd_data  = fill[k];
         cmd_valid = 1'b1;
         if (cmd_ready) begin
            n_acc++;
            exp_q.push_back(model_res(fill[k]));
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("fill_accepted", 32'(n_acc), 32'd4);
      chk("fill_ready_low", 32'(cmd_ready), 32'd0);
      d0 = res_data; starts = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (alu_start) starts++;
      end
      chk("bp_data_stable", 32'(res_data), 32'(d0));
      chk("bp_valid_held", 32'(res_valid), 32'd1);
      chk("bp_no_start", 32'(starts), 32'd0);
      for (int k = 0; k < 5; k++) take_result($sformatf("fill_%0d", k), k % 3);
      repeat (20) @(negedge clk);
      chk("fill_no_extra", 32'(res_valid), 32'd0);

      // Randomized bursts, reserved bits randomized too.
      for (int b = 0; b < 8; b++) begin
         int n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) push_cmd(16'($urandom));
         for (int k = 0; k < n; k++) take_result($sformatf("rnd_%0d_%0d", b, k), $urandom_range(0, 3));
      end
      chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-WAIT with three commands queued.
      core_mute = 1'b1;
      for (int k = 0; k < 4; k++) push_cmd(16'h0011 + 16'(k));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_core_ui",   32'(core_ui),   32'd0);
      chk("midrst_core_uio",  32'(core_uio),  32'd0);
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      core_mute = 1'b0;
      vhits = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (res_valid || alu_start) vhits++;
      end
      chk("midrst_no_result", 32'(vhits), 32'd0);

      // Core never answers.
      core_mute = 1'b1;
      push_cmd(16'h0012);
      exp_q.delete();
`ifdef SEQ_TIMEOUT_EN
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 17) chk("to_valid_before", 32'(res_valid), 32'd0);
         if (k == 18) chk("to_valid_at",     32'(res_valid), 32'd1);
      end
      chk("to_flags", 32'(res_flags), 32'h8);
      chk("to_data",  32'(res_data),  32'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("to_dropped", 32'(res_valid), 32'd0);
`else
      vhits = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (res_valid) vhits++;
      end
      chk("noto_no_result", 32'(vhits), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
      core_mute = 1'b0;

      // Still functional afterwards.
      push_cmd(16'h00F1);
      take_result("post_alu", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
